// File: rtl/control_p4_router.sv
// AXI-Lite 1:N router for the P4 virtual-switch control plane.
// Independent write and read FSMs, one transaction each, with broadcast writes and a per-FSM wait timeout.
module control_p4_router #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_NUM_SLAVES       = 4,
  parameter int C_SEL_LSB          = 16,
  parameter int C_BCAST_BIT        = 20,
  parameter int C_TIMEOUT          = 255
) (
  input  logic                                       M_AXI_ACLK,
  input  logic                                       M_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
  input  logic                                       M_AXI_AWVALID,
  output logic                                       M_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
  input  logic                                       M_AXI_WVALID,
  output logic                                       M_AXI_WREADY,
  output logic                                       M_AXI_BVALID,
  output logic [1:0]                                 M_AXI_BRESP,
  input  logic                                       M_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
  input  logic                                       M_AXI_ARVALID,
  output logic                                       M_AXI_ARREADY,
  output logic                                       M_AXI_RVALID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
  output logic [1:0]                                 M_AXI_RRESP,
  input  logic                                       M_AXI_RREADY,
  output logic [C_NUM_SLAVES*C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  output logic [C_NUM_SLAVES-1:0]                    S_AXI_AWVALID,
  input  logic [C_NUM_SLAVES-1:0]                    S_AXI_AWREADY,
  output logic [C_NUM_SLAVES*C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  output logic [C_NUM_SLAVES*C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic [C_NUM_SLAVES-1:0]                    S_AXI_WVALID,
  input  logic [C_NUM_SLAVES-1:0]                    S_AXI_WREADY,
  input  logic [C_NUM_SLAVES-1:0]                    S_AXI_BVALID,
  input  logic [2*C_NUM_SLAVES-1:0]                  S_AXI_BRESP,
  output logic [C_NUM_SLAVES-1:0]                    S_AXI_BREADY,
  output logic [C_NUM_SLAVES*C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  output logic [C_NUM_SLAVES-1:0]                    S_AXI_ARVALID,
  input  logic [C_NUM_SLAVES-1:0]                    S_AXI_ARREADY,
  input  logic [C_NUM_SLAVES-1:0]                    S_AXI_RVALID,
  input  logic [C_NUM_SLAVES*C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  input  logic [2*C_NUM_SLAVES-1:0]                  S_AXI_RRESP,
  output logic [C_NUM_SLAVES-1:0]                    S_AXI_RREADY
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int N  = C_NUM_SLAVES;
  localparam int SW = DW/8;
  localparam logic [15:0] TMO = 16'(C_TIMEOUT);

  typedef logic [N-1:0] tgt_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA, R_DONE} r_state_t;

  // All-zero result means decode error; reads never broadcast.
  function automatic tgt_t decode(input logic [AW-1:0] a, input logic rd);
    logic [2:0] idx;
    idx    = a[C_SEL_LSB +: 3];
    decode = '0;
    if (a[C_BCAST_BIT])     decode = rd ? '0 : '1;
    else if (32'(idx) < N)  decode = tgt_t'(1) << idx;
  endfunction

  w_state_t        w_state;
  logic [AW-1:0]   aw_addr;
  logic [DW-1:0]   w_data;
  logic [SW-1:0]   w_strb;
  tgt_t            w_tgt, aw_vld, w_vld, b_rdy;
  logic [1:0]      bresp_acc;
  logic [15:0]     wcnt;

  r_state_t        r_state;
  logic [AW-1:0]   ar_addr;
  tgt_t            r_tgt, ar_vld, r_rdy;
  logic [15:0]     rcnt;

  tgt_t            aw_nxt, w_nxt, b_nxt, w_dec, r_dec;
  logic [1:0]      b_max, r_mux_resp;
  logic [DW-1:0]   r_mux_data;
  logic [15:0]     wcnt_nxt, rcnt_nxt;
  logic            w_to, r_to;

  always_comb begin
    w_dec    = decode(M_AXI_AWADDR, 1'b0);
    r_dec    = decode(M_AXI_ARADDR, 1'b1);
    aw_nxt   = aw_vld & ~S_AXI_AWREADY;
    w_nxt    = w_vld & ~S_AXI_WREADY;
    b_nxt    = b_rdy & ~S_AXI_BVALID;
    wcnt_nxt = wcnt + 16'd1;
    rcnt_nxt = rcnt + 16'd1;
    w_to     = wcnt_nxt >= TMO;
    r_to     = rcnt_nxt >= TMO;
    // Broadcast response is the worst (largest) code of the slaves answering now or earlier.
    b_max    = bresp_acc;
    for (int i = 0; i < N; i++)
      if (b_rdy[i] && S_AXI_BVALID[i] && S_AXI_BRESP[2*i +: 2] > b_max) b_max = S_AXI_BRESP[2*i +: 2];
    r_mux_data = '0;
    r_mux_resp = '0;
    for (int i = 0; i < N; i++)
      if (r_tgt[i]) begin
        r_mux_data = S_AXI_RDATA[i*DW +: DW];
        r_mux_resp = S_AXI_RRESP[2*i +: 2];
      end
  end

  assign S_AXI_AWADDR  = {N{aw_addr}};
  assign S_AXI_WDATA   = {N{w_data}};
  assign S_AXI_WSTRB   = {N{w_strb}};
  assign S_AXI_ARADDR  = {N{ar_addr}};
  assign S_AXI_AWVALID = aw_vld;
  assign S_AXI_WVALID  = w_vld;
  assign S_AXI_BREADY  = b_rdy;
  assign S_AXI_ARVALID = ar_vld;
  assign S_AXI_RREADY  = r_rdy;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      w_state <= W_IDLE;
      M_AXI_AWREADY <= 1'b0;
      M_AXI_WREADY  <= 1'b0;
      M_AXI_BVALID  <= 1'b0;
      M_AXI_BRESP   <= 2'b00;
      aw_addr <= '0; w_data <= '0; w_strb <= '0;
      w_tgt <= '0; aw_vld <= '0; w_vld <= '0; b_rdy <= '0;
      bresp_acc <= 2'b00;
      wcnt <= '0;
    end else begin
      M_AXI_AWREADY <= 1'b0;
      M_AXI_WREADY  <= 1'b0;
      case (w_state)
        W_IDLE: if (M_AXI_AWVALID && M_AXI_WVALID) begin
          M_AXI_AWREADY <= 1'b1;
          M_AXI_WREADY  <= 1'b1;
          aw_addr <= M_AXI_AWADDR;
          w_data  <= M_AXI_WDATA;
          w_strb  <= M_AXI_WSTRB;
          if (w_dec == '0) begin
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= 2'b11;
            w_state      <= W_DONE;
          end else begin
            w_tgt     <= w_dec;
            aw_vld    <= w_dec;
            w_vld     <= w_dec;
            bresp_acc <= 2'b00;
            wcnt      <= '0;
            w_state   <= W_FWD;
          end
        end
        W_FWD: begin
          wcnt   <= wcnt_nxt;
          aw_vld <= aw_nxt;
          w_vld  <= w_nxt;
          if (aw_nxt == '0 && w_nxt == '0) begin
            b_rdy   <= w_tgt;
            w_state <= W_RESP;
          end else if (w_to) begin
            aw_vld <= '0;
            w_vld  <= '0;
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= 2'b10;
            w_state      <= W_DONE;
          end
        end
        W_RESP: begin
          wcnt      <= wcnt_nxt;
          b_rdy     <= b_nxt;
          bresp_acc <= b_max;
          if (b_nxt == '0) begin
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= b_max;
            w_state      <= W_DONE;
          end else if (w_to) begin
            b_rdy <= '0;
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= 2'b10;
            w_state      <= W_DONE;
          end
        end
        W_DONE: if (M_AXI_BREADY) begin
          M_AXI_BVALID <= 1'b0;
          M_AXI_BRESP  <= 2'b00;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state <= R_IDLE;
      M_AXI_ARREADY <= 1'b0;
      M_AXI_RVALID  <= 1'b0;
      M_AXI_RRESP   <= 2'b00;
      M_AXI_RDATA   <= '0;
      ar_addr <= '0;
      r_tgt <= '0; ar_vld <= '0; r_rdy <= '0;
      rcnt <= '0;
    end else begin
      M_AXI_ARREADY <= 1'b0;
      case (r_state)
        R_IDLE: if (M_AXI_ARVALID) begin
          M_AXI_ARREADY <= 1'b1;
          ar_addr <= M_AXI_ARADDR;
          if (r_dec == '0) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RRESP  <= 2'b11;
            M_AXI_RDATA  <= '0;
            r_state      <= R_DONE;
          end else begin
            r_tgt   <= r_dec;
            ar_vld  <= r_dec;
            rcnt    <= '0;
            r_state <= R_FWD;
          end
        end
        R_FWD: begin
          rcnt <= rcnt_nxt;
          if (|(ar_vld & S_AXI_ARREADY)) begin
            ar_vld  <= '0;
            r_rdy   <= r_tgt;
            r_state <= R_DATA;
          end else if (r_to) begin
            ar_vld <= '0;
            M_AXI_RVALID <= 1'b1;
            M_AXI_RRESP  <= 2'b10;
            M_AXI_RDATA  <= '0;
            r_state      <= R_DONE;
          end
        end
        R_DATA: begin
          rcnt <= rcnt_nxt;
          if (|(r_rdy & S_AXI_RVALID)) begin
            r_rdy <= '0;
            M_AXI_RVALID <= 1'b1;
            M_AXI_RRESP  <= r_mux_resp;
            M_AXI_RDATA  <= r_mux_data;
            r_state      <= R_DONE;
          end else if (r_to) begin
            r_rdy <= '0;
            M_AXI_RVALID <= 1'b1;
            M_AXI_RRESP  <= 2'b10;
            M_AXI_RDATA  <= '0;
            r_state      <= R_DONE;
          end
        end
        R_DONE: if (M_AXI_RREADY) begin
          M_AXI_RVALID <= 1'b0;
          M_AXI_RRESP  <= 2'b00;
          M_AXI_RDATA  <= '0;
          r_state      <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
